// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer arbiter slice.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_W       = 16;
    localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first asserted
// request at or after the pointer, with wrap.
module rr_select #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic               valid,
    output logic [IDX_W-1:0]   sel
);

    int j;

    always_comb begin
        valid = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(pointer) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!valid && req[j]) begin
                valid = 1'b1;
                sel   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin owner of the shared cycle timer; drives
// t_en for the winner and pulses done at the target count.
module timer_arbiter
    import timer_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int W       = DEF_W,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ*W-1:0] dur,
    output logic [NUM_REQ-1:0] grant,
    output logic [NUM_REQ-1:0] done,
    output logic               busy,
    output logic               t_en,
    input  logic [W-1:0]       t_out,
    input  logic               t_valid
);

    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx, idx_nx;
    logic [IDX_W-1:0]   ptr, ptr_nx;
    logic [W-1:0]       dur_q, dur_nx;
    logic               sel_valid;
    logic [IDX_W-1:0]   sel;
    logic [NUM_REQ-1:0] onehot_nx;
    logic [NUM_REQ-1:0] grant_nx, done_nx;
    logic               t_en_nx, busy_nx;

    rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req     (req),
        .pointer (ptr),
        .valid   (sel_valid),
        .sel     (sel)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            ptr   <= '0;
            dur_q <= '0;
            grant <= '0;
            done  <= '0;
            t_en  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            ptr   <= ptr_nx;
            dur_q <= dur_nx;
            grant <= grant_nx;
            done  <= done_nx;
            t_en  <= t_en_nx;
            busy  <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        ptr_nx   = ptr;
        dur_nx   = dur_q;
        unique case (state)
            ST_IDLE: begin
                if (sel_valid) begin
                    idx_nx = sel;
                    dur_nx = dur[int'(sel)*W +: W];
                    if (int'(sel) == NUM_REQ - 1) ptr_nx = '0;
                    else ptr_nx = sel + IDX_W'(1);
                    // zero-length jobs never raise t_en
                    if (dur_nx == '0) state_nx = ST_DONE;
                    else state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (t_valid && t_out == dur_q) state_nx = ST_DONE;
                else if (!req[idx]) state_nx = ST_IDLE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        onehot_nx = ONE << idx_nx;
        grant_nx  = (state_nx != ST_IDLE) ? onehot_nx : '0;
        done_nx   = (state_nx == ST_DONE) ? onehot_nx : '0;
        t_en_nx   = (state_nx == ST_RUN);
        busy_nx   = (state_nx != ST_IDLE);
    end

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter paired with a
// behavioural model of the shared cycle timer.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] dur   = '0;
    logic [N-1:0]   grant, done;
    logic           busy, t_en, t_valid;
    logic [W-1:0]   t_out;
    logic [W-1:0]   t_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // timer: restarts at 0 when t_en rises, +1 per clock while enabled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) t_cnt <= '0;
        else if (!t_en) t_cnt <= '0;
        else t_cnt <= t_cnt + 16'd1;
    end
    assign t_out   = t_cnt;
    assign t_valid = t_en;

    timer_arbiter #(.NUM_REQ(N), .W(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .dur     (dur),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .t_en    (t_en),
        .t_out   (t_out),
        .t_valid (t_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_dur(input int i, input logic [W-1:0] v);
        dur[i*W +: W] = v;
    endtask

    task automatic do_reset();
        req = '0;
        @(negedge clock);
        reset = 1'b0;
        #20;
        @(negedge clock);
        reset = 1'b1;
    endtask

    int n, k, nj, ndone, gap, lowrun;
    logic prev_ten;
    logic [N-1:0] jobs [5];
    logic [N-1:0] exp_order [5];

    initial begin
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;

        // 1: single job, dur=5
        #20;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_ten", 32'(t_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        set_dur(0, 16'd5);
        req = 4'b0001;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        set_dur(0, 16'd2);
        n = 0;
        while (t_en && n < 50) begin
            check("t1_tout", 32'(t_out), 32'(n));
            check("t1_nodone", 32'(done), 32'h0);
            n++;
            tick();
        end
        check("t1_ten_len", 32'(n), 32'd6);
        check("t1_done", 32'(done), 32'h1);
        check("t1_grant_done", 32'(grant), 32'h1);
        check("t1_busy_done", 32'(busy), 32'h1);
        req = '0;
        tick();
        check("t1_done_off", 32'(done), 32'h0);
        check("t1_busy_off", 32'(busy), 32'h0);
        check("t1_grant_off", 32'(grant), 32'h0);

        // 2: all four requesting, dur=3 each
        do_reset();
        for (int i = 0; i < N; i++) set_dur(i, 16'd3);
        req = 4'b1111;
        nj = 0;
        ndone = 0;
        lowrun = 0;
        prev_ten = 1'b0;
        for (int c = 0; c < 29; c++) begin
            tick();
            check("t2_onehot", 32'($countones(grant) <= 1), 32'h1);
            if (t_en && !prev_ten) begin
                if (nj > 0) begin
                    gap = lowrun;
                    check("t2_gap", 32'(gap >= 1 && gap <= 2), 32'h1);
                end
                if (nj < 5) jobs[nj] = grant;
                nj++;
            end
            if (!t_en) lowrun++;
            else lowrun = 0;
            if (done != '0) begin
                ndone++;
                check("t2_done_owner", 32'(done), 32'(grant));
                check("t2_done_ten", 32'(t_en), 32'h0);
            end
            prev_ten = t_en;
        end
        req = '0;
        check("t2_jobs", 32'(nj), 32'd5);
        for (int i = 0; i < 5; i++)
            check("t2_order", 32'(jobs[i]), 32'(exp_order[i]));
        check("t2_ndone", 32'(ndone), 32'd5);
        tick();
        check("t2_idle", 32'(busy), 32'h0);

        // 3: zero duration on requester 1
        do_reset();
        set_dur(1, 16'd0);
        req = 4'b0010;
        tick();
        check("t3_grant", 32'(grant), 32'h2);
        check("t3_done", 32'(done), 32'h2);
        check("t3_ten", 32'(t_en), 32'h0);
        req = '0;
        tick();
        check("t3_done_off", 32'(done), 32'h0);
        check("t3_ten2", 32'(t_en), 32'h0);
        check("t3_busy", 32'(busy), 32'h0);

        // 4: owner 2 withdraws at t_out=4, requester 0 pending
        set_dur(2, 16'd10);
        set_dur(0, 16'd2);
        req = 4'b0100;
        tick();
        check("t4_grant2", 32'(grant), 32'h4);
        req[0] = 1'b1;
        k = 0;
        while (t_out !== 16'd4 && k < 30) begin
            check("t4_hold", 32'(grant), 32'h4);
            tick();
            k++;
        end
        check("t4_reach4", 32'(t_out), 32'd4);
        req[2] = 1'b0;
        tick();
        check("t4_grant_off", 32'(grant), 32'h0);
        check("t4_ten_off", 32'(t_en), 32'h0);
        check("t4_nodone", 32'(done), 32'h0);
        tick();
        check("t4_grant0", 32'(grant), 32'h1);
        k = 0;
        while (done == '0 && k < 20) begin
            tick();
            k++;
        end
        check("t4_done0", 32'(done), 32'h1);
        req = '0;
        tick();

        // 5: async reset mid-run at t_out=7
        set_dur(2, 16'd20);
        req = 4'b0100;
        tick();
        check("t5_grant2", 32'(grant), 32'h4);
        k = 0;
        while (t_out !== 16'd7 && k < 30) begin
            tick();
            k++;
        end
        check("t5_reach7", 32'(t_out), 32'd7);
        #2;
        reset = 1'b0;
        #1;
        check("t5_grant", 32'(grant), 32'h0);
        check("t5_ten", 32'(t_en), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_done", 32'(done), 32'h0);
        req = 4'b1000;
        set_dur(3, 16'd1);
        @(negedge clock);
        @(negedge clock);
        check("t5_held", 32'(grant), 32'h0);
        reset = 1'b1;
        tick();
        check("t5_grant3", 32'(grant), 32'h8);
        k = 0;
        while (done == '0 && k < 20) begin
            tick();
            k++;
        end
        check("t5_done3", 32'(done), 32'h8);
        req = '0;
        tick();

        // 6: withdraw on the matching cycle still completes
        set_dur(0, 16'd4);
        req = 4'b0001;
        tick();
        check("t6_grant", 32'(grant), 32'h1);
        k = 0;
        while (t_out !== 16'd4 && k < 30) begin
            tick();
            k++;
        end
        check("t6_reach4", 32'(t_out), 32'd4);
        req = '0;
        tick();
        check("t6_done", 32'(done), 32'h1);
        check("t6_ten", 32'(t_en), 32'h0);
        tick();
        check("t6_done_off", 32'(done), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
